// File: rtl/iir_acq_sequencer.sv
// Acquisition sequencer for the IIR stage: flushes and arms the filter,
// discards settling outputs, then forwards samples into the capture FIFO.
module iir_acq_sequencer #(
  parameter int DATA_WIDTH   = 64,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [15:0]           settle_count,
  input  logic [15:0]           sample_count,
  output logic                  filt_reset_n,
  output logic                  filt_enable,
  input  logic                  filt_ready,
  input  logic                  filt_valid,
  input  logic [DATA_WIDTH-1:0] filt_data,
  output logic                  fifo_wr,
  output logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_full,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [15:0]           captured_count
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_ARM,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [FW-1:0]         r_flush_cnt;
  logic [15:0]           r_settle_rem;
  logic [15:0]           r_sample_rem;
  logic [15:0]           r_captured;
  logic                  r_overflow;
  logic                  r_fifo_wr;
  logic [DATA_WIDTH-1:0] r_fifo_data;
  logic                  r_filt_rst_n;

  logic w_start_ok;
  logic w_flush_last;
  logic w_discard;
  logic w_sample;
  logic w_write;

  assign w_start_ok   = (r_state == S_IDLE) && start && !abort;
  assign w_flush_last = (r_flush_cnt == FW'(FLUSH_CYCLES - 1));
  assign w_discard    = (r_state == S_SETTLE) && filt_valid && !abort;
  assign w_sample     = (r_state == S_CAPTURE) && filt_valid && !abort;
  assign w_write      = w_sample && !fifo_full;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_flush_last) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        if (filt_ready) begin
          if (r_settle_rem != 16'd0)      w_state_nxt = S_SETTLE;
          else if (r_sample_rem != 16'd0) w_state_nxt = S_CAPTURE;
          else                            w_state_nxt = S_DONE;
        end
      end
      S_SETTLE: begin
        if (filt_valid && r_settle_rem == 16'd1) begin
          if (r_sample_rem != 16'd0) w_state_nxt = S_CAPTURE;
          else                       w_state_nxt = S_DONE;
        end
      end
      S_CAPTURE: begin
        if (filt_valid && r_sample_rem == 16'd1) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // abort overrides every transition out of a busy state
    if (abort && r_state != S_IDLE) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_filt_rst_n <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_filt_rst_n <= (w_state_nxt != S_FLUSH);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_flush_cnt <= '0;
    end else if (w_start_ok) begin
      r_flush_cnt <= '0;
    end else if (r_state == S_FLUSH) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // remaining-work counters only ever count down to zero, so they never wrap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_settle_rem <= 16'd0;
      r_sample_rem <= 16'd0;
    end else if (w_start_ok) begin
      r_settle_rem <= settle_count;
      r_sample_rem <= sample_count;
    end else begin
      if (w_discard) r_settle_rem <= r_settle_rem - 16'd1;
      if (w_sample)  r_sample_rem <= r_sample_rem - 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_captured <= 16'd0;
      r_overflow <= 1'b0;
    end else if (w_start_ok) begin
      r_captured <= 16'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_write)              r_captured <= r_captured + 16'd1;
      if (w_sample && fifo_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fifo_wr   <= 1'b0;
      r_fifo_data <= '0;
    end else begin
      r_fifo_wr <= w_write;
      if (w_write) r_fifo_data <= filt_data;
    end
  end

  assign filt_reset_n   = r_filt_rst_n;
  assign filt_enable    = (r_state == S_ARM) ||
                          (r_state == S_SETTLE) ||
                          (r_state == S_CAPTURE);
  assign fifo_wr        = r_fifo_wr;
  assign fifo_data      = r_fifo_data;
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign overflow       = r_overflow;
  assign captured_count = r_captured;

endmodule
